// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding,
// instruction memory depth and the default terminator word.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int          MEM_DEPTH         = 256;
    localparam logic [15:0] END_INSTR_DEFAULT = 16'hFFFF;

    // Combine the two bytes of a pair into one instruction word.
    function automatic logic [15:0] assemble_word(input logic [7:0] first_b,
                                                  input logic [7:0] second_b,
                                                  input logic       msb_first);
        return msb_first ? {first_b, second_b} : {second_b, first_b};
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: pairs incoming bytes into 16-bit words and
// writes them to sequential instruction-memory addresses until a terminator or full.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [15:0] END_INSTR = END_INSTR_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_en_write,
    output logic [7:0]  o_addr_write,
    output logic [15:0] o_instr_write,
    output logic [8:0]  o_instr_count,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_full
);

    localparam logic [8:0] LAST_COUNT = 9'(MEM_DEPTH - 1);

    state_e      state;
    logic [7:0]  first_byte;
    logic [15:0] word_asm;
    logic        byte_take;

    // Ready depends on state alone so the source never sees a valid->ready loop.
    assign o_byte_ready = (state == S_FIRST) || (state == S_SECOND);
    assign byte_take    = i_byte_valid && o_byte_ready;
    assign word_asm     = assemble_word(first_byte, i_byte, MSB_FIRST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            first_byte    <= '0;
            o_en_write    <= 1'b0;
            o_addr_write  <= '0;
            o_instr_write <= '0;
            o_instr_count <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_full        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state         <= S_FIRST;
                        o_instr_count <= '0;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                        o_full        <= 1'b0;
                    end
                end
                S_FIRST: begin
                    if (byte_take) begin
                        first_byte <= i_byte;
                        state      <= S_SECOND;
                    end
                end
                S_SECOND: begin
                    if (byte_take) begin
                        if (word_asm == END_INSTR) begin
                            state  <= S_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state         <= S_WRITE;
                            o_en_write    <= 1'b1;
                            o_addr_write  <= o_instr_count[7:0];
                            o_instr_write <= word_asm;
                        end
                    end
                end
                S_WRITE: begin
                    o_en_write    <= 1'b0;
                    o_instr_count <= o_instr_count + 9'd1;
                    // The 256th write closes the session before the address can wrap.
                    if (o_instr_count == LAST_COUNT) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_full <= 1'b1;
                    end else begin
                        state <= S_FIRST;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    o_en_write <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: one MSB-first and one LSB-first instance share
// the stimulus; write strobes are logged and compared with hand-computed words.
module tb_instr_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_byte;
    logic        i_byte_valid;

    logic        rdy, wen, busy, done, full;
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [8:0]  cnt;

    logic        l_rdy, l_wen, l_busy, l_done, l_full;
    logic [7:0]  l_addr;
    logic [15:0] l_instr;
    logic [8:0]  l_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [23:0] wq[$];
    logic [23:0] lq[$];

    always #5 i_clk = ~i_clk;

    instr_loader #(.END_INSTR(16'hFFFF), .MSB_FIRST(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_byte_ready(rdy), .o_en_write(wen),
        .o_addr_write(addr), .o_instr_write(instr), .o_instr_count(cnt),
        .o_busy(busy), .o_done(done), .o_full(full)
    );

    instr_loader #(.END_INSTR(16'hFFFF), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_byte_ready(l_rdy), .o_en_write(l_wen),
        .o_addr_write(l_addr), .o_instr_write(l_instr), .o_instr_count(l_cnt),
        .o_busy(l_busy), .o_done(l_done), .o_full(l_full)
    );

    always @(negedge i_clk) begin
        if (wen)   wq.push_back({addr, instr});
        if (l_wen) lq.push_back({l_addr, l_instr});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Offer a byte after `gap` idle cycles and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        i_byte_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        t = 0;
        while (!rdy && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ready"}, 32'(rdy), 32'd0);
        chk({tag, "_en"},    32'(wen), 32'd0);
        chk({tag, "_addr"},  32'(addr), 32'd0);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_count"}, 32'(cnt), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_full"},  32'(full), 32'd0);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] a,
                               input logic [15:0] d);
        if (idx < wq.size()) chk(tag, 32'(wq[idx]), 32'({a, d}));
        else                 chk({tag, "_missing"}, 32'(wq.size()), 32'(idx + 1));
    endtask

    initial begin
        logic [7:0] seq[6];
        logic [15:0] w;
        int bad;

        i_rst_n = 1'b0; i_start = 1'b0; i_byte = '0; i_byte_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check_outputs_zero("reset");
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("idle_busy",  32'(busy), 32'd0);
        chk("idle_ready", 32'(rdy),  32'd0);

        // Basic load, MSB first
        seq = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
        wq.delete(); lq.delete();
        pulse_start();
        chk("start_busy",  32'(busy), 32'd1);
        chk("start_ready", 32'(rdy),  32'd1);
        for (int i = 0; i < 6; i++) send_byte(seq[i], 0);
        chk("basic_nwr", 32'(wq.size()), 32'd2);
        check_write("basic_w0", 0, 8'd0, 16'h1234);
        check_write("basic_w1", 1, 8'd1, 16'hABCD);
        chk("basic_done",  32'(done), 32'd1);
        chk("basic_busy",  32'(busy), 32'd0);
        chk("basic_count", 32'(cnt),  32'd2);
        chk("basic_full",  32'(full), 32'd0);
        chk("basic_hold_addr",  32'(addr),  32'h01);
        chk("basic_hold_instr", 32'(instr), 32'hABCD);

        // Byte order: 34 12 -> LSB-first instance writes 1234
        wq.delete(); lq.delete();
        pulse_start();
        chk("restart_count", 32'(cnt),  32'd0);
        chk("restart_done",  32'(done), 32'd0);
        send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        chk("lsb_nwr", 32'(lq.size()), 32'd1);
        if (lq.size() > 0) chk("lsb_w0", 32'(lq[0]), 32'h001234);
        check_write("msb_w0_swapped", 0, 8'd0, 16'h3412);
        chk("lsb_count", 32'(l_cnt), 32'd1);

        // Backpressure: random gaps, plus a byte offered during WRITE
        wq.delete(); lq.delete();
        pulse_start();
        send_byte(8'h12, $urandom_range(0, 3));
        send_byte(8'h34, $urandom_range(0, 3));
        i_byte = 8'h56; i_byte_valid = 1'b1;
        chk("bp_write_en",    32'(wen), 32'd1);
        chk("bp_write_ready", 32'(rdy), 32'd0);
        @(negedge i_clk);
        chk("bp_first_ready", 32'(rdy), 32'd1);
        chk("bp_count",       32'(cnt), 32'd1);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        send_byte(8'h78, $urandom_range(0, 3));
        send_byte(8'hAB, $urandom_range(0, 3));
        send_byte(8'hCD, $urandom_range(0, 3));
        send_byte(8'hFF, $urandom_range(0, 3));
        send_byte(8'hFF, $urandom_range(0, 3));
        chk("bp_nwr", 32'(wq.size()), 32'd3);
        check_write("bp_w0", 0, 8'd0, 16'h1234);
        check_write("bp_w1", 1, 8'd1, 16'h5678);
        check_write("bp_w2", 2, 8'd2, 16'hABCD);
        chk("bp_count_final", 32'(cnt), 32'd3);

        // Full: 256 words, no terminator
        wq.delete(); lq.delete();
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i)};
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        @(negedge i_clk);
        chk("full_nwr", 32'(wq.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wq.size() && i < 256; i++)
            if (wq[i] !== {8'(i), 8'(i), ~8'(i)}) bad++;
        chk("full_seq_bad", 32'(bad), 32'd0);
        chk("full_full",  32'(full), 32'd1);
        chk("full_count", 32'(cnt),  32'd256);
        chk("full_done",  32'(done), 32'd1);
        i_byte = 8'h11; i_byte_valid = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("full_ready_after", 32'(rdy), 32'd0);
        chk("full_no_extra", 32'(wq.size()), 32'd256);
        i_byte_valid = 1'b0;

        // Reset mid-word
        wq.delete(); lq.delete();
        pulse_start();
        send_byte(8'h12, 0);
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("midrst_nwr",  32'(wq.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        pulse_start();
        send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        chk("midrst_nwr2", 32'(wq.size()), 32'd1);
        check_write("midrst_w0", 0, 8'd0, 16'h5678);

        // Start ignored in SECOND, honoured in DONE
        wq.delete(); lq.delete();
        pulse_start();
        send_byte(8'h12, 0);
        pulse_start();
        chk("ign_ready", 32'(rdy),  32'd1);
        chk("ign_busy",  32'(busy), 32'd1);
        send_byte(8'h34, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        check_write("ign_w0", 0, 8'd0, 16'h1234);
        chk("ign_count", 32'(cnt), 32'd1);
        pulse_start();
        chk("redo_count", 32'(cnt),  32'd0);
        chk("redo_done",  32'(done), 32'd0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        send_byte(8'hFF, 0); send_byte(8'hFF, 0);
        chk("redo_nwr", 32'(wq.size()), 32'd2);
        check_write("redo_w0", 1, 8'd0, 16'hABCD);
        chk("redo_count_final", 32'(cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter END_INSTR, default 16'hFFFF: terminator word; ends loading and is never written.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first byte of each pair is bits [15:8], 0 = first byte is bits [7:0].
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  one-cycle pulse; begins a new load session.
REQ-006 i_byte  input  8  incoming instruction byte.
REQ-007 i_byte_valid  input  1  i_byte is valid this cycle.
REQ-008 o_byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 o_en_write  output  1  instruction-memory write strobe.
REQ-010 o_addr_write  output  8  instruction-memory write address.
REQ-011 o_instr_write  output  16  instruction-memory write data.
REQ-012 o_instr_count  output  9  instructions written this session, range 0..256.
REQ-013 o_busy  output  1  session in progress.
REQ-014 o_done  output  1  session finished; held high until the next i_start.
REQ-015 o_full  output  1  session ended because 256 words were written.

Function
REQ-016 FSM states: IDLE, FIRST, SECOND, WRITE, DONE.
REQ-017 A byte SHALL be accepted only on an edge where i_byte_valid and o_byte_ready are both high.
REQ-018 o_byte_ready SHALL be high only in FIRST and SECOND; it is combinational from state only, never from i_byte_valid.
REQ-019 IDLE or DONE with i_start high: go to FIRST; clear o_instr_count, o_done and o_full.
REQ-020 i_start SHALL be ignored in FIRST, SECOND and WRITE.
REQ-021 FIRST with a byte accepted: store the byte as the first half and go to SECOND.
REQ-022 SECOND with a byte accepted: assemble the 16-bit word per MSB_FIRST.
REQ-023 If the assembled word equals END_INSTR, go to DONE with no write; otherwise go to WRITE.
REQ-024 WRITE lasts exactly one cycle, with o_en_write=1, o_addr_write=o_instr_count[7:0] and o_instr_write=assembled word.
REQ-025 On leaving WRITE, o_instr_count SHALL increment by 1.
REQ-026 On leaving WRITE, if the new count is 256, go to DONE and set o_full; otherwise go to FIRST.
REQ-027 Latency: second byte accepted at edge N -> o_en_write high in the cycle following edge N; next byte accepted no earlier than edge N+2.
REQ-028 o_en_write SHALL be 0 in every state except WRITE.
REQ-029 o_addr_write and o_instr_write SHALL hold their last written values outside WRITE.
REQ-030 Writes SHALL use strictly sequential addresses 0,1,2,... with no gaps, so the memory's last-written-address tracking is correct.
REQ-031 o_busy SHALL be high in FIRST, SECOND and WRITE; o_done SHALL be high only in DONE.
REQ-032 o_instr_count SHALL never exceed 256, and the 8-bit address SHALL never wrap within a session.
REQ-033 In DONE, o_instr_count holds the final count until the next i_start.

Reset
REQ-034 On i_rst_n low, asynchronously: state=IDLE and every output = 0 (o_en_write, o_addr_write, o_instr_write, o_instr_count, o_busy, o_done, o_full, o_byte_ready).
REQ-035 Reset asserted mid-session SHALL abort the session; a half-assembled word is discarded and no write is issued.
REQ-036 After reset release, the loader SHALL stay in IDLE until i_start.

Structure
REQ-037 A shared package instr_loader_pkg SHALL hold: the state enum, the MEM_DEPTH=256 constant, and the default END_INSTR constant.
REQ-038 The block is one module with no sub-module.
REQ-039 Byte assembly and the FSM SHALL both reside in instr_loader.

Verification
REQ-040 Basic load, MSB_FIRST=1: i_start, then bytes 12 34 AB CD FF FF -> writes (0,1234), (1,ABCD); then o_done=1, o_instr_count=2, o_full=0.
REQ-041 Byte order, MSB_FIRST=0: bytes 34 12 -> write (0,1234).
REQ-042 Backpressure: i_byte_valid toggled at random -> identical writes; a byte offered during WRITE is not consumed (o_byte_ready=0).
REQ-043 Full: 512 bytes with no terminator -> 256 writes at addresses 0..255; o_full=1, o_instr_count=256; o_byte_ready stays 0 afterwards.
REQ-044 Reset mid-word: i_rst_n pulsed low after first byte 12 -> no write; all outputs 0. A new i_start then bytes 56 78 FF FF -> write (0,5678).
REQ-045 Restart and ignored start: i_start pulsed during SECOND -> ignored. i_start pulsed in DONE -> count cleared; the next word is written at address 0.
